// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and writeback request type for the register-file writeback path
package rf_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADR_W = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_ADR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: small circular buffer of ALU writeback requests with every slot visible for hazard checks
module rf_wb_fifo import rf_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  wb_req_t             push_req,
  input  logic                pop,
  output logic [PW:0]         count,
  output wb_req_t             head,
  output wb_req_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]    valid
);
  wb_req_t [DEPTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] cnt;
  // payload storage needs no reset: occupancy is tracked by cnt alone
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_req;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      cnt    <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    assign valid[i] = {1'b0, PW'(PW'(i) - rd_ptr)} < cnt;
  end
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign entries = mem;
endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: arbitrates load and buffered ALU writebacks onto one register-file write port and tracks load hazards
module rf_wb_ctrl import rf_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [REG_ADR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  output logic                 alu_ready,
  input  logic                 ld_valid,
  input  logic [REG_ADR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]      ld_data,
  input  logic                 ld_issue,
  input  logic [REG_ADR_W-1:0] ld_issue_rd,
  input  logic [REG_ADR_W-1:0] chk_rs1,
  input  logic [REG_ADR_W-1:0] chk_rs2,
  input  logic [REG_ADR_W-1:0] chk_rd,
  output logic                 stall,
  output logic [REG_ADR_W-1:0] adr_rd,
  output logic [XLEN-1:0]      din_rd,
  output logic                 regwrite
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] count;
  wb_req_t head;
  wb_req_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0] valid;
  logic push, pop, wr_en, fifo_hit;
  logic [REG_ADR_W-1:0] wr_rd;
  logic [XLEN-1:0] wr_data;
  logic [NUM_REGS-1:0] pending, clr_mask, set_mask;
  assign alu_ready = rst_n && (count < CW'(DEPTH));
  assign push      = alu_valid && alu_ready;
  assign pop       = !ld_valid && (count != '0);
  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_req ('{rd: alu_rd, data: alu_data}),
    .pop      (pop),
    .count    (count),
    .head     (head),
    .entries  (entries),
    .valid    (valid)
  );
  // load responses win the port; x0 targets are consumed without a write
  always_comb begin
    wr_rd   = ld_valid ? ld_rd : head.rd;
    wr_data = ld_valid ? ld_data : head.data;
    wr_en   = (ld_valid || pop) && (wr_rd != '0);
  end
  // registered write port; address and data hold when no write is issued
  always_ff @(posedge clk)
    if (!rst_n) begin
      regwrite <= 1'b0;
      adr_rd   <= '0;
      din_rd   <= '0;
    end else begin
      regwrite <= wr_en;
      adr_rd   <= wr_en ? wr_rd : adr_rd;
      din_rd   <= wr_en ? wr_data : din_rd;
    end
  assign clr_mask = {NUM_REGS{ld_valid}} & (NUM_REGS'(1) << ld_rd);
  assign set_mask = {NUM_REGS{ld_issue}} & (NUM_REGS'(1) << ld_issue_rd) & ~NUM_REGS'(1);
  // scoreboard of outstanding loads; a new issue beats a same-register clear
  always_ff @(posedge clk)
    if (!rst_n) pending <= '0;
    else pending <= (pending & ~clr_mask) | set_mask;
  // decode must hold on an outstanding load or a buffered ALU write to any operand or destination
  always_comb begin
    fifo_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      fifo_hit = fifo_hit || (valid[i] && entries[i].rd != '0 &&
                 (entries[i].rd == chk_rs1 || entries[i].rd == chk_rs2 || entries[i].rd == chk_rd));
    stall = pending[chk_rs1] || pending[chk_rs2] || pending[chk_rd] || fifo_hit;
  end
  a_ld_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (ld_valid && ld_rd != '0) |-> pending[ld_rd]);
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: directed and randomized checks of rf_wb_ctrl against a queue-based reference model
module tb_rf_wb_ctrl;
  import rf_pkg::*;
  localparam int D = 4;
  logic clk = 0, rst_n = 0;
  logic alu_valid = 0, ld_valid = 0, ld_issue = 0;
  logic [4:0] alu_rd = 0, ld_rd = 0, ld_issue_rd = 0, chk_rs1 = 0, chk_rs2 = 0, chk_rd = 0;
  logic [31:0] alu_data = 0, ld_data = 0;
  logic alu_ready, stall, regwrite;
  logic [4:0] adr_rd;
  logic [31:0] din_rd;
  wb_req_t q[$];
  bit pend[32];
  logic m_we = 0;
  logic [4:0] m_adr = 0;
  logic [31:0] m_din = 0;
  int tests = 0, fails = 0;
  rf_wb_ctrl #(.DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .stall(stall), .adr_rd(adr_rd), .din_rd(din_rd), .regwrite(regwrite)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit m_stall();
    bit s = pend[chk_rs1] | pend[chk_rs2] | pend[chk_rd];
    foreach (q[i])
      if (q[i].rd != 0 && (q[i].rd == chk_rs1 || q[i].rd == chk_rs2 || q[i].rd == chk_rd)) s = 1;
    return s;
  endfunction
  task automatic idle();
    alu_valid = 0; ld_valid = 0; ld_issue = 0;
  endtask
  task automatic step();
    bit acc;
    wb_req_t r;
    @(negedge clk);
    chk("alu_ready", alu_ready, 32'(rst_n && q.size() < D));
    chk("stall", stall, 32'(m_stall()));
    chk("regwrite", regwrite, 32'(m_we));
    chk("adr_rd", adr_rd, 32'(m_adr));
    chk("din_rd", din_rd, m_din);
    @(posedge clk);
    acc = alu_valid && rst_n && q.size() < D;
    if (!rst_n) begin
      q.delete();
      foreach (pend[i]) pend[i] = 0;
      m_we = 0; m_adr = 0; m_din = 0;
    end else begin
      m_we = 0;
      if (ld_valid) begin
        if (ld_rd != 0) begin m_we = 1; m_adr = ld_rd; m_din = ld_data; end
        pend[ld_rd] = 0;
      end else if (q.size() > 0) begin
        r = q.pop_front();
        if (r.rd != 0) begin m_we = 1; m_adr = r.rd; m_din = r.data; end
      end
      if (acc) q.push_back('{rd: alu_rd, data: alu_data});
      if (ld_issue && ld_issue_rd != 0) pend[ld_issue_rd] = 1;
    end
    #1;
  endtask
  initial begin
    int lst[$];
    repeat (2) @(posedge clk);
    #1;
    step(); step();
    rst_n = 1;
    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; step();
    idle(); step();
    chk("t029_we", regwrite, 1); chk("t029_adr", adr_rd, 5); chk("t029_din", din_rd, 32'hDEADBEEF);
    // load beats a same-cycle ALU request
    ld_issue = 1; ld_issue_rd = 7; step(); idle();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11; ld_valid = 1; ld_rd = 7; ld_data = 32'h22; step();
    chk("t030_adr1", adr_rd, 7); chk("t030_din1", din_rd, 32'h22);
    idle(); step();
    chk("t030_adr2", adr_rd, 3); chk("t030_din2", din_rd, 32'h11);
    // loads hold the port while the buffer fills
    for (int i = 0; i < 4; i++) begin ld_issue = 1; ld_issue_rd = 5'(10 + i); step(); end
    idle();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(20 + i); alu_data = 32'(i + 100);
      ld_valid = 1; ld_rd = 5'(10 + i); ld_data = 32'(i); step();
    end
    chk("t031_full", alu_ready, 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t031_order", adr_rd, 32'(20 + i));
    end
    step();
    // scoreboard stall on outstanding load
    ld_issue = 1; ld_issue_rd = 9; chk_rs1 = 9; step(); idle();
    chk("t032_stall_set", stall, 1);
    step(); step();
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99; step(); idle();
    chk("t032_stall_clr", stall, 0); chk("t032_adr", adr_rd, 9);
    chk_rs1 = 0; step();
    // x0 is never written nor pending
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF; step(); idle();
    step();
    chk("t033_we", regwrite, 0);
    ld_issue = 1; ld_issue_rd = 0; step(); idle();
    step();
    // reset discards buffered entries and pending bits
    ld_issue = 1; ld_issue_rd = 4; alu_valid = 1; alu_rd = 1; alu_data = 1; ld_valid = 1; ld_rd = 0; step();
    ld_issue = 0; alu_rd = 2; alu_data = 2; step();
    idle(); rst_n = 0; step();
    chk("t034_we", regwrite, 0);
    rst_n = 1; chk_rs1 = 4; #1;
    chk("t034_ready", alu_ready, 1); chk("t034_stall", stall, 0);
    step(); step();
    chk("t034_we2", regwrite, 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = $urandom_range(0, 99) != 0;
      alu_valid = $urandom_range(0, 1) == 1;
      alu_rd = 5'($urandom_range(0, 7));
      alu_data = $urandom;
      lst.delete();
      foreach (pend[i]) if (pend[i]) lst.push_back(i);
      ld_data = $urandom;
      if (lst.size() > 0 && $urandom_range(0, 2) == 0) begin
        ld_valid = 1; ld_rd = 5'(lst[$urandom_range(0, lst.size() - 1)]);
      end else begin
        ld_valid = $urandom_range(0, 9) == 0; ld_rd = 0;
      end
      ld_issue = $urandom_range(0, 3) == 0;
      ld_issue_rd = 5'($urandom_range(0, 7));
      chk_rs1 = 5'($urandom_range(0, 7));
      chk_rs2 = 5'($urandom_range(0, 7));
      chk_rd = 5'($urandom_range(0, 7));
      step();
    end
    idle(); rst_n = 1;
    repeat (6) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
